mem_arbiter: RTL and testbench

- Shares the single 16-bit word-addressed memory between two requesters: the instruction-fetch port (read-only) and the data load/store port (read/write).
- Grants at most one access per cycle.
- Sequences the memory's timing: the memory registers the address on posedge and updates q on negedge only while r is high.
- Returns read data to the owning requester with a valid strobe.
- Sits between the CPU core and the memory.

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory between the instruction-fetch
// port (read-only) and the data load/store port. At most one access is issued
// per cycle. Read data comes back from the memory one cycle after the grant,
// together with a one-cycle valid strobe for the requester that owns it.
module mem_arbiter #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic                  d_lock,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_w,
   output logic                  mem_r,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   owner_t                owner_p1;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  starved;
   logic                  fetch_win;
   logic                  data_win;
   logic [ADDR_WIDTH-1:0] addr_last;
   logic [DATA_WIDTH-1:0] data_last;

   // Issue stage: pick the winner; requests are ignored while reset is held
   always_comb begin
      starved   = (starve_cnt == LIMIT);
      fetch_win = rst_n & if_req & (~d_req | (starved & ~d_lock));
      data_win  = rst_n & d_req & ~fetch_win;
      if (fetch_win) begin
         mem_addr = if_addr;
      end else if (data_win) begin
         mem_addr = d_addr;
      end else begin
         mem_addr = addr_last;
      end
      mem_data = data_win ? d_wdata : data_last;
   end

   assign if_gnt = fetch_win;
   assign d_gnt  = data_win;
   assign mem_w  = data_win & d_we;

   // Keep the last driven address/data on the memory bus while nobody is granted
   always_ff @(posedge clk) begin
      if (fetch_win | data_win) begin
         addr_last <= mem_addr;
      end
      if (data_win) begin
         data_last <= d_wdata;
      end
   end

   // Response stage: record who owns next cycle's read data and track fetch starvation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_p1   <= OWN_NONE;
         starve_cnt <= '0;
      end else begin
         if (fetch_win) begin
            owner_p1 <= OWN_IF;
         end else if (data_win & ~d_we) begin
            owner_p1 <= OWN_D;
         end else begin
            owner_p1 <= OWN_NONE;
         end

         if (if_req & ~fetch_win) begin
            starve_cnt <= starved ? starve_cnt : starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   assign mem_r     = (owner_p1 != OWN_NONE);
   assign if_rvalid = (owner_p1 == OWN_IF);
   assign d_rvalid  = (owner_p1 == OWN_D);
   assign if_rdata  = mem_q;
   assign d_rdata   = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural memory and
// a transaction-level model that predicts grants, write effects and read data.
module tb_mem_arbiter;

   localparam int DW  = 16;
   localparam int AW  = 16;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic          d_lock = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_w;
   logic          mem_r;
   logic [DW-1:0] mem_q = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_w(mem_w), .mem_r(mem_r),
      .mem_q(mem_q)
   );

   // Memory: address and write on posedge, q updated on negedge only while r is high
   logic [DW-1:0] ram [0:65535];
   logic [AW-1:0] ram_addr_q = '0;
   always @(posedge clk) begin
      ram_addr_q <= mem_addr;
      if (mem_w) ram[mem_addr] <= mem_data;
   end
   always @(negedge clk) begin
      if (mem_r) mem_q <= ram[ram_addr_q];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: contents of memory, starvation count, and the one pending read
   logic [DW-1:0] mdl_mem [0:65535];
   int            m_cnt = 0;
   bit            m_pend_if = 1'b0;
   bit            m_pend_d = 1'b0;
   logic [DW-1:0] m_pend_data = '0;

   initial begin
      bit e_if, e_d;
      forever begin
         @(posedge clk);
         #8;
         if (!rst_n) begin
            chk("rst_if_gnt", 32'(if_gnt), 0);
            chk("rst_d_gnt", 32'(d_gnt), 0);
            chk("rst_mem_w", 32'(mem_w), 0);
            chk("rst_if_rvalid", 32'(if_rvalid), 0);
            chk("rst_d_rvalid", 32'(d_rvalid), 0);
            chk("rst_mem_r", 32'(mem_r), 0);
            m_cnt = 0;
            m_pend_if = 1'b0;
            m_pend_d = 1'b0;
         end else begin
            e_if = if_req && (!d_req || (m_cnt == LIM && !d_lock));
            e_d  = d_req && !e_if;
            chk("if_gnt", 32'(if_gnt), 32'(e_if));
            chk("d_gnt", 32'(d_gnt), 32'(e_d));
            chk("mem_w", 32'(mem_w), 32'(e_d && d_we));
            if (e_if) chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
            else if (e_d) chk("mem_addr_d", 32'(mem_addr), 32'(d_addr));
            if (e_d && d_we) chk("mem_data", 32'(mem_data), 32'(d_wdata));
            chk("if_rvalid", 32'(if_rvalid), 32'(m_pend_if));
            chk("d_rvalid", 32'(d_rvalid), 32'(m_pend_d));
            chk("mem_r", 32'(mem_r), 32'(m_pend_if || m_pend_d));
            if (m_pend_if) chk("if_rdata", 32'(if_rdata), 32'(m_pend_data));
            if (m_pend_d) chk("d_rdata", 32'(d_rdata), 32'(m_pend_data));
            if (e_d && d_we) mdl_mem[d_addr] = d_wdata;
            m_pend_if   = e_if;
            m_pend_d    = e_d && !d_we;
            m_pend_data = e_if ? mdl_mem[if_addr] : mdl_mem[d_addr];
            if (if_req && !e_if) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
            else m_cnt = 0;
         end
      end
   end

   // One cycle of stimulus: drive just after posedge, return just before the next
   task automatic cyc(input logic ir, input logic [AW-1:0] ia, input logic dr,
                      input logic dw, input logic dl, input logic [AW-1:0] da,
                      input logic [DW-1:0] dd);
      @(posedge clk);
      #1;
      if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_lock = dl;
      d_addr = da; d_wdata = dd;
      #7;
   endtask

   task automatic idle();
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
      ram[a] = v;
      mdl_mem[a] = v;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         ram[i] = 16'(i) ^ 16'hA5A5;
         mdl_mem[i] = 16'(i) ^ 16'hA5A5;
      end
      set_word(16'h0010, 16'hBEEF);
      set_word(16'h0001, 16'h1111);
      set_word(16'h0002, 16'h2222);

      // Requests during reset are ignored
      cyc(1'b1, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h5555);
      chk("lit_rst_if_gnt", 32'(if_gnt), 0);
      chk("lit_rst_mem_w", 32'(mem_w), 0);
      idle();
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Fetch only
      cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("lit_f_gnt", 32'(if_gnt), 1);
      chk("lit_f_addr", 32'(mem_addr), 32'h0010);
      idle();
      chk("lit_f_rvalid", 32'(if_rvalid), 1);
      chk("lit_f_rdata", 32'(if_rdata), 32'hBEEF);
      chk("lit_f_d_rvalid", 32'(d_rvalid), 0);
      idle();
      chk("lit_f_rvalid_off", 32'(if_rvalid), 0);

      // Write then read the same address
      cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h1234);
      chk("lit_wr_gnt", 32'(d_gnt), 1);
      chk("lit_wr_mem_w", 32'(mem_w), 1);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000);
      chk("lit_rd_gnt", 32'(d_gnt), 1);
      chk("lit_rd_mem_w", 32'(mem_w), 0);
      chk("lit_wr_no_rvalid", 32'(d_rvalid), 0);
      idle();
      chk("lit_rd_rvalid", 32'(d_rvalid), 1);
      chk("lit_rd_rdata", 32'(d_rdata), 32'h1234);
      idle();

      // Contention without lock: four data grants, then fetch, repeating
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 16'h0030, 1'b1, 1'b0, 1'b0, 16'(16'h0040 + i), '0);
         chk("lit_cont_if_gnt", 32'(if_gnt), 32'(i == 4 || i == 9));
      end
      idle();

      // Lock holds off fetch; releasing it with a saturated counter lets fetch in
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 16'h0050, 1'b1, 1'b0, 1'b1, 16'(16'h0060 + i), '0);
         chk("lit_lock_if_gnt", 32'(if_gnt), 0);
      end
      cyc(1'b1, 16'h0050, 1'b1, 1'b0, 1'b0, 16'h0070, '0);
      chk("lit_unlock_if_gnt", 32'(if_gnt), 1);
      chk("lit_unlock_d_gnt", 32'(d_gnt), 0);
      idle();
      idle();

      // Interleaved fetch and data reads
      cyc(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, '0, '0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'h0002, '0);
      chk("lit_il_if_rvalid", 32'(if_rvalid), 1);
      chk("lit_il_if_rdata", 32'(if_rdata), 32'h1111);
      chk("lit_il_d_rvalid0", 32'(d_rvalid), 0);
      chk("lit_il_mem_r1", 32'(mem_r), 1);
      idle();
      chk("lit_il_d_rvalid", 32'(d_rvalid), 1);
      chk("lit_il_d_rdata", 32'(d_rdata), 32'h2222);
      chk("lit_il_if_rvalid0", 32'(if_rvalid), 0);
      chk("lit_il_mem_r2", 32'(mem_r), 1);
      idle();
      chk("lit_il_mem_r_off", 32'(mem_r), 0);

      // Fetch withdraws before being granted: no access for it
      cyc(1'b1, 16'h0080, 1'b1, 1'b0, 1'b1, 16'h0090, '0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 16'h0091, '0);
      idle();
      idle();

      // Async reset while a data read response is in flight, counter nonzero
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 16'h00A0, 1'b1, 1'b0, 1'b0, 16'(16'h00B0 + i), '0);
      end
      @(posedge clk);
      #1;
      if_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
      #1;
      chk("lit_mid_d_rvalid_pre", 32'(d_rvalid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("lit_mid_d_rvalid", 32'(d_rvalid), 0);
      chk("lit_mid_if_rvalid", 32'(if_rvalid), 0);
      chk("lit_mid_mem_r", 32'(mem_r), 0);
      chk("lit_mid_cnt", 32'(dut.starve_cnt), 0);
      #4;
      idle();
      @(posedge clk);
      #3 rst_n = 1'b1;
      idle();
      chk("lit_post_if_rvalid", 32'(if_rvalid), 0);
      chk("lit_post_d_rvalid", 32'(d_rvalid), 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0, 16'(16'h00D0 + i), '0);
         chk("lit_post_cont_if_gnt", 32'(if_gnt), 32'(i == 4));
      end
      idle();
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
